// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg: shared op/state encodings and default width for the ALU command responder.
package alu_cmd_pkg;
    localparam int DEF_WIDTH = 4;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_CMP = 2'b10, OP_AND = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, RESP = 2'b10} state_e;
endpackage

// File: rtl/alu_core_comb.sv
// alu_core_comb: combinational 4-op ALU datapath (add, sub, compare, and).
module alu_core_comb
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             agtb,
    output logic             aeqb,
    output logic             bgta
);
    logic [WIDTH:0] sum, diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    // top bit of a + ~b + 1 is the no-borrow flag
    assign diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    always_comb begin
        result = op == OP_ADD ? sum[WIDTH-1:0] : op == OP_SUB ? diff[WIDTH-1:0] : op == OP_AND ? (a & b) : '0;
        carry  = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? diff[WIDTH] : 1'b0;
        agtb   = op == OP_CMP && a > b;
        aeqb   = op == OP_CMP && a == b;
        bgta   = op == OP_CMP && b > a;
    end
endmodule

// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder: valid/ready front-end to alu_core_comb (IDLE -> EXEC -> RESP).
// Define ALU_OPCOUNT_EN to enable the saturating completed-response counter on op_count.
module alu_cmd_responder
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_s0,
    input  logic             req_s1,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_op,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_agtb,
    output logic             rsp_aeqb,
    output logic             rsp_bgta,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    state_e           state, state_nx;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, c_res;
    logic             c_carry, c_agtb, c_aeqb, c_bgta;

    always_comb begin
        state_nx  = state == IDLE ? (req_valid ? EXEC : IDLE) :
                    state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
        busy      = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_ADD;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nx;
            if (req_valid && req_ready) begin
                op_q <= op_e'({req_s1, req_s0});
                a_q  <= req_a;
                b_q  <= req_b;
            end
        end
    end

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .op(op_q), .a(a_q), .b(b_q), .result(c_res),
        .carry(c_carry), .agtb(c_agtb), .aeqb(c_aeqb), .bgta(c_bgta)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_op     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_agtb   <= 1'b0;
            rsp_aeqb   <= 1'b0;
            rsp_bgta   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_op     <= op_q;
            rsp_result <= c_res;
            rsp_carry  <= c_carry;
            rsp_agtb   <= c_agtb;
            rsp_aeqb   <= c_aeqb;
            rsp_bgta   <= c_bgta;
        end
    end

`ifdef ALU_OPCOUNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (rsp_valid && rsp_ready && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign op_count = cnt;
`else
    assign op_count = '0;
`endif
endmodule
